voice_scheduler: RTL and testbench

Polyphony controller for the keyboard synthesizer. It accepts key press/release events decoded from the SPI frame. It assigns each pressed key to one of NVOICE tone voices and runs a per-voice attack/sustain/release envelope. Per voice it emits a note code and a gain word, which drive the tone generators, per-voice attenuators and the note summer, together with the active-voice count the summer uses for normalisation.

---
 rtl/voice_scheduler_if.sv | 34 +++
 rtl/voice_scheduler.sv | 258 +++++++++++++++++++++++++
 tb/tb_voice_scheduler.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/voice_scheduler_if.sv
// ---------------------------------------------------------------------------
// voice_scheduler_if
// Groups the key-event handshake and the per-voice output bus of the
// polyphony controller.
//   ev_valid/ev_ready/ev_press/ev_note : key event handshake (master -> slave)
//   voice_note   : NVOICE x 8-bit note codes, voice i at [8i+7:8i]
//   voice_gain   : NVOICE x GAIN_W envelope gains, voice i at [GAIN_W*i +: GAIN_W]
//   voice_active : one bit per voice, set while the voice is not idle
//   notescount   : number of active voices
// The scheduler uses the slave modport; the event source uses master.
// ---------------------------------------------------------------------------
interface voice_scheduler_if #(
    parameter int NVOICE = 3,
    parameter int GAIN_W = 5
);
    logic                            ev_valid;
    logic                            ev_ready;
    logic                            ev_press;
    logic [7:0]                      ev_note;
    logic [NVOICE*8-1:0]             voice_note;
    logic [NVOICE*GAIN_W-1:0]        voice_gain;
    logic [NVOICE-1:0]               voice_active;
    logic [$clog2(NVOICE+1)-1:0]     notescount;

    modport master (
        output ev_valid, ev_press, ev_note,
        input  ev_ready, voice_note, voice_gain, voice_active, notescount
    );

    modport slave (
        input  ev_valid, ev_press, ev_note,
        output ev_ready, voice_note, voice_gain, voice_active, notescount
    );
endinterface

// File: rtl/voice_scheduler.sv
// ---------------------------------------------------------------------------
// voice_scheduler
// Polyphony controller: assigns pressed keys to NVOICE tone voices and runs
// an attack/sustain/release gain envelope per voice.
// Ports:
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : voice_scheduler_if.slave (event handshake + per-voice outputs)
// An accepted event is latched in WAIT and applied one clock later in APPLY,
// so ev_ready drops for exactly one cycle per event.
// ---------------------------------------------------------------------------
module voice_scheduler #(
    parameter int NVOICE  = 3,
    parameter int GAIN_W  = 5,
    parameter int ATK_DIV = 78125,
    parameter int REL_DIV = 312500
) (
    input  logic                    clk,
    input  logic                    reset_n,
    voice_scheduler_if.slave        bus
);

    localparam int CNT_W  = $clog2(NVOICE + 1);
    localparam int VIDX_W = (NVOICE > 1) ? $clog2(NVOICE) : 1;
    localparam int ATK_W  = (ATK_DIV > 1) ? $clog2(ATK_DIV) : 1;
    localparam int REL_W  = (REL_DIV > 1) ? $clog2(REL_DIV) : 1;

    localparam logic [GAIN_W-1:0] GMAX     = '1;
    localparam logic [ATK_W-1:0]  ATK_LAST = ATK_W'(ATK_DIV - 1);
    localparam logic [REL_W-1:0]  REL_LAST = REL_W'(REL_DIV - 1);
    localparam logic [VIDX_W-1:0] VLAST    = VIDX_W'(NVOICE - 1);

    typedef enum logic {S_WAIT, S_APPLY} fsm_t;
    typedef enum logic [1:0] {V_IDLE, V_ATTACK, V_SUSTAIN, V_RELEASE} vstate_t;
    typedef enum logic [1:0] {K_RETRIG, K_NEW, K_REL} kind_t;

    // ---------------- prescalers (free running) ----------------
    logic [ATK_W-1:0] r_atk_cnt;
    logic [REL_W-1:0] r_rel_cnt;
    logic             w_atk_tick;
    logic             w_rel_tick;

    assign w_atk_tick = (r_atk_cnt == ATK_LAST);
    assign w_rel_tick = (r_rel_cnt == REL_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_atk_cnt <= '0;
            r_rel_cnt <= '0;
        end else begin
            r_atk_cnt <= w_atk_tick ? '0 : r_atk_cnt + 1'b1;
            r_rel_cnt <= w_rel_tick ? '0 : r_rel_cnt + 1'b1;
        end
    end

    // ---------------- event FSM ----------------
    fsm_t r_fsm;
    fsm_t w_fsm_next;
    logic w_ev_ready;
    logic w_apply;
    logic w_accept;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_fsm <= S_WAIT;
        else          r_fsm <= w_fsm_next;
    end

    always_comb begin
        w_fsm_next = r_fsm;
        case (r_fsm)
            S_WAIT:  if (bus.ev_valid) w_fsm_next = S_APPLY;
            S_APPLY: w_fsm_next = S_WAIT;
            default: w_fsm_next = S_WAIT;
        endcase
    end

    always_comb begin
        w_ev_ready = (r_fsm == S_WAIT);
        w_apply    = (r_fsm == S_APPLY);
    end

    assign w_accept     = bus.ev_valid && w_ev_ready;
    assign bus.ev_ready = w_ev_ready;

    logic       r_ev_press;
    logic [7:0] r_ev_note;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ev_press <= 1'b0;
            r_ev_note  <= '0;
        end else if (w_accept) begin
            r_ev_press <= bus.ev_press;
            r_ev_note  <= bus.ev_note;
        end
    end

    // ---------------- voice registers ----------------
    vstate_t            r_vstate [NVOICE];
    logic [7:0]         r_note   [NVOICE];
    logic [GAIN_W-1:0]  r_gain   [NVOICE];
    logic [NVOICE-1:0]  r_active;
    logic [CNT_W-1:0]   r_count;
    logic [VIDX_W-1:0]  r_steal_ptr;

    vstate_t            w_vstate_next [NVOICE];
    logic [7:0]         w_note_next   [NVOICE];
    logic [GAIN_W-1:0]  w_gain_next   [NVOICE];
    logic [NVOICE-1:0]  w_active_next;
    logic [CNT_W-1:0]   w_count_next;

    // ---------------- target voice selection ----------------
    logic               w_hit_found,  w_idle_found, w_rel_found, w_off_found;
    logic [VIDX_W-1:0]  w_hit_idx,    w_idle_idx,   w_rel_idx,   w_off_idx;
    logic [GAIN_W-1:0]  w_rel_gain;
    logic               w_tgt_valid;
    logic [VIDX_W-1:0]  w_tgt_idx;
    kind_t              w_tgt_kind;
    logic               w_rr_adv;

    always_comb begin
        w_hit_found  = 1'b0;  w_hit_idx  = '0;
        w_idle_found = 1'b0;  w_idle_idx = '0;
        w_rel_found  = 1'b0;  w_rel_idx  = '0;  w_rel_gain = '0;
        w_off_found  = 1'b0;  w_off_idx  = '0;
        for (int i = 0; i < NVOICE; i++) begin
            if (!w_hit_found && r_vstate[i] != V_IDLE && r_note[i] == r_ev_note) begin
                w_hit_found = 1'b1;
                w_hit_idx   = VIDX_W'(i);
            end
            if (!w_idle_found && r_vstate[i] == V_IDLE) begin
                w_idle_found = 1'b1;
                w_idle_idx   = VIDX_W'(i);
            end
            // Strict '<' keeps the lowest index on equal gains.
            if (r_vstate[i] == V_RELEASE && (!w_rel_found || r_gain[i] < w_rel_gain)) begin
                w_rel_found = 1'b1;
                w_rel_idx   = VIDX_W'(i);
                w_rel_gain  = r_gain[i];
            end
            if (!w_off_found && (r_vstate[i] == V_ATTACK || r_vstate[i] == V_SUSTAIN)
                && r_note[i] == r_ev_note) begin
                w_off_found = 1'b1;
                w_off_idx   = VIDX_W'(i);
            end
        end
    end

    always_comb begin
        w_tgt_valid = 1'b0;
        w_tgt_idx   = '0;
        w_tgt_kind  = K_NEW;
        w_rr_adv    = 1'b0;
        // Note 0x00 is consumed without effect.
        if (w_apply && r_ev_note != 8'h00) begin
            if (r_ev_press) begin
                w_tgt_valid = 1'b1;
                if (w_hit_found) begin
                    w_tgt_idx  = w_hit_idx;
                    w_tgt_kind = K_RETRIG;
                end else if (w_idle_found) begin
                    w_tgt_idx  = w_idle_idx;
                end else if (w_rel_found) begin
                    w_tgt_idx  = w_rel_idx;
                end else begin
                    w_tgt_idx  = r_steal_ptr;
                    w_rr_adv   = 1'b1;
                end
            end else if (w_off_found) begin
                w_tgt_valid = 1'b1;
                w_tgt_idx   = w_off_idx;
                w_tgt_kind  = K_REL;
            end
        end
    end

    // ---------------- per-voice next state ----------------
    always_comb begin
        w_count_next  = '0;
        w_active_next = '0;
        for (int i = 0; i < NVOICE; i++) begin
            w_vstate_next[i] = r_vstate[i];
            w_note_next[i]   = r_note[i];
            w_gain_next[i]   = r_gain[i];
            case (r_vstate[i])
                V_ATTACK: if (w_atk_tick) begin
                    // Saturate at GMAX; reaching it ends the attack.
                    if (r_gain[i] >= GMAX - 1'b1) begin
                        w_gain_next[i]   = GMAX;
                        w_vstate_next[i] = V_SUSTAIN;
                    end else begin
                        w_gain_next[i]   = r_gain[i] + 1'b1;
                    end
                end
                V_RELEASE: if (w_rel_tick) begin
                    // Saturate at 0; reaching it frees the voice.
                    if (r_gain[i] <= GAIN_W'(1)) begin
                        w_gain_next[i]   = '0;
                        w_vstate_next[i] = V_IDLE;
                        w_note_next[i]   = '0;
                    end else begin
                        w_gain_next[i]   = r_gain[i] - 1'b1;
                    end
                end
                default: ;
            endcase
            // The event overrides any envelope step on its own voice.
            if (w_tgt_valid && w_tgt_idx == VIDX_W'(i)) begin
                w_gain_next[i] = r_gain[i];
                w_note_next[i] = r_note[i];
                case (w_tgt_kind)
                    K_RETRIG: w_vstate_next[i] = V_ATTACK;
                    K_REL:    w_vstate_next[i] = V_RELEASE;
                    default: begin
                        w_vstate_next[i] = V_ATTACK;
                        w_note_next[i]   = r_ev_note;
                        w_gain_next[i]   = '0;
                    end
                endcase
            end
            w_active_next[i] = (w_vstate_next[i] != V_IDLE);
            w_count_next     = w_count_next + CNT_W'(w_active_next[i]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NVOICE; i++) begin
                r_vstate[i] <= V_IDLE;
                r_note[i]   <= '0;
                r_gain[i]   <= '0;
            end
            r_active    <= '0;
            r_count     <= '0;
            r_steal_ptr <= '0;
        end else begin
            for (int i = 0; i < NVOICE; i++) begin
                r_vstate[i] <= w_vstate_next[i];
                r_note[i]   <= w_note_next[i];
                r_gain[i]   <= w_gain_next[i];
            end
            r_active <= w_active_next;
            r_count  <= w_count_next;
            if (w_rr_adv)
                r_steal_ptr <= (r_steal_ptr == VLAST) ? '0 : r_steal_ptr + 1'b1;
        end
    end

    // ---------------- output packing ----------------
    for (genvar gi = 0; gi < NVOICE; gi++) begin : g_pack
        assign bus.voice_note[8*gi +: 8]           = r_note[gi];
        assign bus.voice_gain[GAIN_W*gi +: GAIN_W] = r_gain[gi];
    end

    assign bus.voice_active = r_active;
    assign bus.notescount   = r_count;

endmodule

// File: tb/tb_voice_scheduler.sv
module tb_voice_scheduler;

    localparam int NV   = 3;
    localparam int GW   = 5;
    localparam int AD   = 4;
    localparam int RD   = 8;
    localparam int GMAX = 31;

    localparam int M_IDLE = 0, M_ATK = 1, M_SUS = 2, M_REL = 3;

    logic clk;
    logic reset_n;

    voice_scheduler_if #(.NVOICE(NV), .GAIN_W(GW)) bus ();

    voice_scheduler #(
        .NVOICE(NV), .GAIN_W(GW), .ATK_DIV(AD), .REL_DIV(RD)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int  m_st   [NV];
    int  m_note [NV];
    int  m_gain [NV];
    int  m_ptr;
    bit  m_busy;
    bit  m_lp;
    int  m_ln;
    int  m_edge;

    always @(posedge clk or negedge reset_n) begin : model
        int ns [NV];
        int nn [NV];
        int ng [NV];
        int tgt;
        int nptr;
        bit atk, rel;
        if (!reset_n) begin
            for (int i = 0; i < NV; i++) begin
                m_st[i] <= M_IDLE; m_note[i] <= 0; m_gain[i] <= 0;
            end
            m_ptr <= 0; m_busy <= 0; m_lp <= 0; m_ln <= 0; m_edge <= 0;
        end else begin
            atk  = (m_edge % AD) == AD - 1;
            rel  = (m_edge % RD) == RD - 1;
            nptr = m_ptr;
            for (int i = 0; i < NV; i++) begin
                ns[i] = m_st[i]; nn[i] = m_note[i]; ng[i] = m_gain[i];
                if (m_st[i] == M_ATK && atk) begin
                    ng[i] = (m_gain[i] + 1 > GMAX) ? GMAX : m_gain[i] + 1;
                    if (ng[i] == GMAX) ns[i] = M_SUS;
                end
                if (m_st[i] == M_REL && rel) begin
                    ng[i] = (m_gain[i] - 1 < 0) ? 0 : m_gain[i] - 1;
                    if (ng[i] == 0) begin ns[i] = M_IDLE; nn[i] = 0; end
                end
            end
            if (m_busy && m_ln != 0) begin
                tgt = -1;
                if (m_lp) begin
                    for (int i = 0; i < NV; i++)
                        if (tgt < 0 && m_st[i] != M_IDLE && m_note[i] == m_ln) tgt = i;
                    if (tgt >= 0) begin
                        ns[tgt] = M_ATK; nn[tgt] = m_note[tgt]; ng[tgt] = m_gain[tgt];
                    end else begin
                        for (int i = 0; i < NV; i++)
                            if (tgt < 0 && m_st[i] == M_IDLE) tgt = i;
                        if (tgt < 0)
                            for (int i = 0; i < NV; i++)
                                if (m_st[i] == M_REL && (tgt < 0 || m_gain[i] < m_gain[tgt])) tgt = i;
                        if (tgt < 0) begin
                            tgt  = m_ptr;
                            nptr = (m_ptr + 1) % NV;
                        end
                        ns[tgt] = M_ATK; nn[tgt] = m_ln; ng[tgt] = 0;
                    end
                end else begin
                    for (int i = 0; i < NV; i++)
                        if (tgt < 0 && (m_st[i] == M_ATK || m_st[i] == M_SUS) && m_note[i] == m_ln) tgt = i;
                    if (tgt >= 0) begin
                        ns[tgt] = M_REL; nn[tgt] = m_note[tgt]; ng[tgt] = m_gain[tgt];
                    end
                end
            end
            if (m_busy) begin
                m_busy <= 0;
            end else if (bus.ev_valid) begin
                m_busy <= 1;
                m_lp   <= bus.ev_press;
                m_ln   <= int'(bus.ev_note);
            end
            for (int i = 0; i < NV; i++) begin
                m_st[i] <= ns[i]; m_note[i] <= nn[i]; m_gain[i] <= ng[i];
            end
            m_ptr  <= nptr;
            m_edge <= m_edge + 1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin : compare
        logic [NV*8-1:0]  e_note;
        logic [NV*GW-1:0] e_gain;
        logic [NV-1:0]    e_act;
        int               e_cnt;
        if (reset_n) begin
            e_cnt = 0;
            for (int i = 0; i < NV; i++) begin
                e_note[8*i +: 8]   = 8'(m_note[i]);
                e_gain[GW*i +: GW] = GW'(m_gain[i]);
                e_act[i]           = (m_st[i] != M_IDLE);
                e_cnt             += (m_st[i] != M_IDLE) ? 1 : 0;
            end
            chk("cyc_ready",  64'(bus.ev_ready),     64'(!m_busy));
            chk("cyc_notes",  64'(bus.voice_note),   64'(e_note));
            chk("cyc_gains",  64'(bus.voice_gain),   64'(e_gain));
            chk("cyc_active", 64'(bus.voice_active), 64'(e_act));
            chk("cyc_count",  64'(bus.notescount),   64'(e_cnt));
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input bit p, input logic [7:0] n);
        int guard = 0;
        while (!bus.ev_ready && guard < 8) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.ev_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_ready_timeout: ev_ready stuck at %0b, required 1", bus.ev_ready);
        end
        bus.ev_valid = 1'b1;
        bus.ev_press = p;
        bus.ev_note  = n;
        @(negedge clk);
        bus.ev_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_gain(input int v, input int g, input string nm);
        int guard = 0;
        while (m_gain[v] != g && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        chk(nm, 64'(m_gain[v]), 64'(g));
    endtask

    logic [7:0] note_tab [6];
    int         rdy_cnt;

    initial begin
        note_tab[0] = 8'h00; note_tab[1] = 8'h3C; note_tab[2] = 8'h40;
        note_tab[3] = 8'h43; note_tab[4] = 8'h48; note_tab[5] = 8'h4A;
        reset_n      = 1'b0;
        bus.ev_valid = 1'b0;
        bus.ev_press = 1'b0;
        bus.ev_note  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_notes", 64'(bus.voice_note), 64'h0);
        chk("rst_gains", 64'(bus.voice_gain), 64'h0);
        chk("rst_count", 64'(bus.notescount), 64'h0);
        chk("rst_ready", 64'(bus.ev_ready), 64'h1);
        reset_n = 1'b1;

        // 1: single press, full attack
        send(1'b1, 8'h3C);
        @(negedge clk);
        chk("t1_note0",  64'(bus.voice_note), 64'h3C);
        chk("t1_active", 64'(bus.voice_active), 64'h1);
        chk("t1_count",  64'(bus.notescount), 64'h1);
        repeat (31 * AD + 4) @(negedge clk);
        chk("t1_gain_full", 64'(bus.voice_gain[4:0]), 64'd31);

        // 2: round-robin steal when nothing is releasing
        do_reset();
        send(1'b1, 8'h3C); send(1'b1, 8'h40); send(1'b1, 8'h43);
        repeat (140) @(negedge clk);
        chk("t2_all_sus_gain", 64'(bus.voice_gain), 64'h7FFF);
        send(1'b1, 8'h48);
        @(negedge clk);
        chk("t2_steal0_note", 64'(bus.voice_note), 64'h43403C & 64'hFFFF00 | 64'h48);
        chk("t2_steal0_gain", 64'(bus.voice_gain[4:0]), 64'd0);
        send(1'b1, 8'h4A);
        @(negedge clk);
        chk("t2_steal1_note", 64'(bus.voice_note), 64'h434A48);
        chk("t2_count", 64'(bus.notescount), 64'd3);

        // 3: release to idle
        do_reset();
        send(1'b1, 8'h3C); send(1'b1, 8'h40); send(1'b1, 8'h43);
        repeat (140) @(negedge clk);
        send(1'b0, 8'h40);
        repeat (31 * RD + 16) @(negedge clk);
        chk("t3_note1",  64'(bus.voice_note), 64'h43003C);
        chk("t3_active", 64'(bus.voice_active), 64'b101);
        chk("t3_count",  64'(bus.notescount), 64'd2);

        // 4: retrigger during release, then steal lowest releasing gain
        send(1'b0, 8'h3C);
        wait_gain(0, 10, "t4_wait_g10");
        send(1'b1, 8'h3C);
        @(negedge clk);
        chk("t4_retrig_gain", 64'(bus.voice_gain[4:0]), 64'd10);
        chk("t4_retrig_notes", 64'(bus.voice_note), 64'h43003C);
        send(1'b1, 8'h40);
        repeat (140) @(negedge clk);
        send(1'b0, 8'h43);
        wait_gain(2, 20, "t4_wait_v2_20");
        send(1'b0, 8'h40);
        wait_gain(2, 4, "t4_wait_v2_4");
        send(1'b1, 8'h50);
        @(negedge clk);
        chk("t4_steal_v2", 64'(bus.voice_note), 64'h50403C);

        // 5: ignored events still take one busy cycle
        repeat (3) @(negedge clk);
        send(1'b0, 8'h55);
        chk("t5_busy_rel", 64'(bus.ev_ready), 64'h0);
        @(negedge clk);
        chk("t5_ready_rel", 64'(bus.ev_ready), 64'h1);
        chk("t5_notes_rel", 64'(bus.voice_note), 64'h50403C);
        send(1'b1, 8'h00);
        chk("t5_busy_zero", 64'(bus.ev_ready), 64'h0);
        @(negedge clk);
        chk("t5_notes_zero", 64'(bus.voice_note), 64'h50403C);
        repeat (2) @(negedge clk);
        rdy_cnt      = 0;
        bus.ev_valid = 1'b1;
        bus.ev_press = 1'b1;
        bus.ev_note  = 8'h00;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.ev_ready) rdy_cnt++;
        end
        bus.ev_valid = 1'b0;
        chk("t5_throughput", 64'(rdy_cnt), 64'd6);

        // 6: asynchronous reset mid-attack
        @(negedge clk);
        send(1'b1, 8'h60);
        repeat (10) @(negedge clk);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_notes", 64'(bus.voice_note), 64'h0);
        chk("t6_gains", 64'(bus.voice_gain), 64'h0);
        chk("t6_active", 64'(bus.voice_active), 64'h0);
        chk("t6_count", 64'(bus.notescount), 64'h0);
        chk("t6_ready", 64'(bus.ev_ready), 64'h1);

        // random traffic against the model
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 250; k++) begin
            repeat ($urandom_range(0, 12)) @(negedge clk);
            if ($urandom_range(0, 15) == 0) repeat (300) @(negedge clk);
            send(1'($urandom_range(0, 1)), note_tab[$urandom_range(0, 5)]);
        end
        repeat (20) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
